// File: rtl/dadda_mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dadda_mul_arbiter_if
// Description : Requester and response bus bundle for dadda_mul_arbiter.
//               master = requesters/consumer side, slave = arbiter side.
// Revision    : 1.0  initial release
// ============================================================================
interface dadda_mul_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int IDW   = 2
) ();
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_prod;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_prod
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_prod
   );
endinterface
`default_nettype wire

// File: rtl/dadda_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dadda_mul_arbiter (with helper dadda_mul16)
// Description : Shares one 16x16 unsigned combinational multiplier among NREQ
//               requesters. Round-robin grant, operand capture, registered
//               product tagged with the requester index.
//               Optional macro DADDA_ARB_PRIO_EN: requester 0 gets fixed
//               highest priority, the others rotate among themselves.
// Revision    : 1.0  initial release
// ============================================================================

// 16x16 unsigned multiplier: partial-product rows reduced in carry-save form,
// followed by a single carry-propagate add.
module dadda_mul16 (
   input  wire logic [15:0] i_a,
   input  wire logic [15:0] i_b,
   output logic      [31:0] o_mul
);
   // Carry-save reduction of the 16 partial products, then the final add.
   always_comb begin : p_reduce
      logic [31:0] w_sum;
      logic [31:0] w_carry;
      logic [31:0] w_pp;
      logic [31:0] w_sum_n;
      logic [31:0] w_carry_n;
      w_sum     = '0;
      w_carry   = '0;
      w_pp      = '0;
      w_sum_n   = '0;
      w_carry_n = '0;
      for (int i = 0; i < 16; i++) begin
         w_pp      = i_b[i] ? ({16'd0, i_a} << i) : 32'd0;
         w_sum_n   = w_sum ^ w_carry ^ w_pp;
         w_carry_n = ((w_sum & w_carry) | (w_sum & w_pp) | (w_carry & w_pp)) << 1;
         w_sum     = w_sum_n;
         w_carry   = w_carry_n;
      end
      // The true product fits in 32 bits, so dropping bit-31 carries is exact.
      o_mul = w_sum + w_carry;
   end
endmodule

module dadda_mul_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,   // only 16 is supported by the shared multiplier
   parameter int CNT_W = 16
) (
   input  wire logic           clk,
   input  wire logic           rst,
   dadda_mul_arbiter_if.slave  bus,
   output logic                busy,
   output logic [CNT_W-1:0]    done_cnt
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIDTH-1:0]    r_op_a;
   logic [WIDTH-1:0]    r_op_b;
   logic [IDW-1:0]      r_op_id;
   logic [IDW-1:0]      r_rr_ptr;
   logic [IDW-1:0]      r_rsp_id;
   logic [2*WIDTH-1:0]  r_rsp_prod;
   logic                r_rsp_valid;
   logic [CNT_W-1:0]    r_done_cnt;
   logic [2*WIDTH-1:0]  w_mul;
   logic                w_gnt_vld;
   logic [IDW-1:0]      w_gnt_idx;
   logic                w_take;
   logic                w_accept;
   logic                w_rsp_hs;
   logic [NREQ-1:0]     w_req_ready;

   // The multiplier only ever sees the captured operands.
   dadda_mul16 u_mul (
      .i_a   (r_op_a),
      .i_b   (r_op_b),
      .o_mul (w_mul)
   );

   // Grant selection: scan upward from the slot after the last winner, wrapping.
   always_comb begin : p_grant
      int             j;
      logic [IDW-1:0] w_j;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      j         = 0;
      w_j       = '0;
`ifdef DADDA_ARB_PRIO_EN
      if (bus.req_valid[0]) begin
         w_gnt_vld = 1'b1;
         w_gnt_idx = '0;
      end
`endif
      for (int k = 1; k <= NREQ; k++) begin
         j = int'(r_rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         w_j = IDW'(j);
`ifdef DADDA_ARB_PRIO_EN
         if (!w_gnt_vld && (j != 0) && bus.req_valid[w_j]) begin
`else
         if (!w_gnt_vld && bus.req_valid[w_j]) begin
`endif
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_j;
         end
      end
   end

   // Next-state logic; w_take marks the cycles in which a new grant may be issued.
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_take = 1'b1;
            if (w_gnt_vld) w_state_nxt = S_CALC;
         end
         S_CALC: w_state_nxt = S_RESP;
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_take      = 1'b1;
               w_state_nxt = w_gnt_vld ? S_CALC : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = w_take & w_gnt_vld;
   assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;

   // One-hot ready towards the winning requester, only in the accepting cycle.
   always_comb begin
      w_req_ready = '0;
      if (w_accept) w_req_ready[w_gnt_idx] = 1'b1;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Operand capture, product register, round-robin pointer and op counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_id     <= '0;
         r_rr_ptr    <= IDW'(NREQ - 1);
         r_rsp_id    <= '0;
         r_rsp_prod  <= '0;
         r_rsp_valid <= 1'b0;
         r_done_cnt  <= '0;
      end else begin
         if (w_accept) begin
            r_op_a  <= bus.req_a[w_gnt_idx*WIDTH +: WIDTH];
            r_op_b  <= bus.req_b[w_gnt_idx*WIDTH +: WIDTH];
            r_op_id <= w_gnt_idx;
`ifdef DADDA_ARB_PRIO_EN
            // Requester 0 sits outside the rotation.
            if (w_gnt_idx != '0) r_rr_ptr <= w_gnt_idx;
`else
            r_rr_ptr <= w_gnt_idx;
`endif
         end
         if (r_state == S_CALC) begin
            r_rsp_prod  <= w_mul;
            r_rsp_id    <= r_op_id;
            r_rsp_valid <= 1'b1;
         end else if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_prod  = r_rsp_prod;
   assign busy          = (r_state != S_IDLE);
   assign done_cnt      = r_done_cnt;
endmodule
`default_nettype wire

// File: tb/tb_dadda_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dadda_mul_arbiter
// Description : Self-checking bench for dadda_mul_arbiter. Expected products
//               are queued at each grant and compared at each rsp handshake.
//               Honours DADDA_ARB_PRIO_EN for arbitration expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dadda_mul_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int IDW   = 2;
   localparam int CNT_W = 16;
   localparam int M_IDLE = 0;
   localparam int M_CALC = 1;
   localparam int M_RESP = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             busy;
   logic [CNT_W-1:0] done_cnt;

   dadda_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   dadda_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .done_cnt (done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] prod;
   } exp_t;

   exp_t                  sb[$];
   int                    checks   = 0;
   int                    failures = 0;
   int                    m_phase;
   int                    m_rr;
   logic [CNT_W-1:0]      m_done;
   int                    issued[NREQ];
   int                    completed[NREQ];
   logic [NREQ*WIDTH-1:0] cur_a;
   logic [NREQ*WIDTH-1:0] cur_b;

   // Reference arbitration: next valid requester after rr, wrapping.
   function automatic int exp_grant(input logic [NREQ-1:0] v, input int rr);
      int j;
`ifdef DADDA_ARB_PRIO_EN
      if (v[0]) return 0;
`endif
      for (int k = 1; k <= NREQ; k++) begin
         j = (rr + k) % NREQ;
`ifdef DADDA_ARB_PRIO_EN
         if (j != 0 && v[j[1:0]]) return j;
`else
         if (v[j[1:0]]) return j;
`endif
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = M_IDLE;
      m_rr    = NREQ - 1;
      m_done  = '0;
      sb.delete();
      for (int i = 0; i < NREQ; i++) begin
         issued[i]    = 0;
         completed[i] = 0;
      end
   endtask

   // Entered and left at posedge+1.
   task automatic do_reset();
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   // One clock of stimulus with scoreboard bookkeeping. hs_id = DUT rsp_id at a
   // handshake, else -1.
   task automatic run_cycle(input logic [NREQ-1:0] v, input logic rr_in, output int hs_id);
      int              g;
      logic [NREQ-1:0] exp_rdy;
      logic            gp;
      logic            hs;
      exp_t            e;
      logic [15:0]     aa;
      logic [15:0]     bb;
      hs_id         = -1;
      bus.req_valid = v;
      bus.req_a     = cur_a;
      bus.req_b     = cur_b;
      bus.rsp_ready = rr_in;
      #1;
      hs = (m_phase == M_RESP) && rr_in;
      gp = (m_phase == M_IDLE) || hs;
      g  = gp ? exp_grant(v, m_rr) : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g[1:0]] = 1'b1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
         failures++;
         $display("FAIL req_ready: got %b expected %b (valid=%b) at %0t", bus.req_ready, exp_rdy, v, $time);
      end
      if (hs) begin
         hs_id = int'(bus.rsp_id);
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected: got id=%0d prod=%h with empty scoreboard at %0t", bus.rsp_id, bus.rsp_prod, $time);
         end else begin
            e = sb.pop_front();
            if (bus.rsp_id !== IDW'(e.id) || bus.rsp_prod !== e.prod) begin
               failures++;
               $display("FAIL rsp_data: got id=%0d prod=%h expected id=%0d prod=%h at %0t", bus.rsp_id, bus.rsp_prod, e.id, e.prod, $time);
            end
            completed[e.id]++;
         end
         m_done = m_done + 1'b1;
      end
      if (g >= 0) begin
         aa     = cur_a[g*WIDTH +: WIDTH];
         bb     = cur_b[g*WIDTH +: WIDTH];
         e.id   = g;
         e.prod = {16'd0, aa} * {16'd0, bb};
         sb.push_back(e);
         issued[g]++;
`ifdef DADDA_ARB_PRIO_EN
         if (g != 0) m_rr = g;
`else
         m_rr = g;
`endif
      end
      case (m_phase)
         M_IDLE:  if (g >= 0) m_phase = M_CALC;
         M_CALC:  m_phase = M_RESP;
         default: if (hs) m_phase = (g >= 0) ? M_CALC : M_IDLE;
      endcase
      @(posedge clk);
      #1;
      checks++;
      if (busy !== (m_phase != M_IDLE) || bus.rsp_valid !== (m_phase == M_RESP) || done_cnt !== m_done) begin
         failures++;
         $display("FAIL status: got busy=%b rsp_valid=%b done_cnt=%0d expected busy=%b rsp_valid=%b done_cnt=%0d at %0t",
                  busy, bus.rsp_valid, done_cnt, (m_phase != M_IDLE), (m_phase == M_RESP), m_done, $time);
      end
   endtask

   task automatic test_reset();
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      cur_a = '0;
      cur_b = '0;
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_prod !== '0 || busy !== 1'b0 || done_cnt !== '0) begin
         failures++;
         $display("FAIL reset_state: got rsp_valid=%b id=%0d prod=%h busy=%b done=%0d expected all zero",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_prod, busy, done_cnt);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic check_resp(input string name, input int id, input logic [31:0] prod);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(id) || bus.rsp_prod !== prod) begin
         failures++;
         $display("FAIL %s: got valid=%b id=%0d prod=%h expected valid=1 id=%0d prod=%h",
                  name, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, id, prod);
      end
   endtask

   task automatic test_basic();
      int hs;
      cur_a = '0; cur_b = '0;
      cur_a[15:0] = 16'd3; cur_b[15:0] = 16'd5;
      run_cycle(4'b0001, 1'b0, hs);
      run_cycle(4'b0000, 1'b0, hs);
      check_resp("basic_3x5", 0, 32'd15);
      run_cycle(4'b0000, 1'b1, hs);
      cur_a[31:16] = 16'hFFFF; cur_b[31:16] = 16'hFFFF;
      run_cycle(4'b0010, 1'b0, hs);
      run_cycle(4'b0000, 1'b0, hs);
      check_resp("basic_max", 1, 32'hFFFE0001);
      run_cycle(4'b0000, 1'b1, hs);
      cur_a[31:16] = 16'h0000; cur_b[31:16] = 16'h1234;
      run_cycle(4'b0010, 1'b0, hs);
      run_cycle(4'b0000, 1'b0, hs);
      check_resp("basic_zero", 1, 32'd0);
      run_cycle(4'b0000, 1'b1, hs);
   endtask

   task automatic test_back_to_back();
      int hs;
      int n = 0;
      int last_cyc = -1;
      int exp_ids[5];
`ifdef DADDA_ARB_PRIO_EN
      exp_ids = '{0, 0, 0, 0, 0};
`else
      exp_ids = '{0, 1, 2, 3, 0};
`endif
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         cur_a[i*WIDTH +: WIDTH] = 16'(100 + i);
         cur_b[i*WIDTH +: WIDTH] = 16'(7 * i + 1);
      end
      for (int c = 0; c < 20 && n < 5; c++) begin
         run_cycle(4'b1111, 1'b1, hs);
         if (hs >= 0) begin
            checks++;
            if (hs !== exp_ids[n] || (last_cyc >= 0 && c - last_cyc != 2)) begin
               failures++;
               $display("FAIL b2b_order: handshake %0d got id=%0d gap=%0d expected id=%0d gap=2", n, hs, c - last_cyc, exp_ids[n]);
            end
            last_cyc = c;
            n++;
         end
      end
      checks++;
      if (n != 5 || done_cnt !== 16'd5) begin
         failures++;
         $display("FAIL b2b_count: got handshakes=%0d done_cnt=%0d expected 5 and 5", n, done_cnt);
      end
   endtask

   task automatic test_stall();
      int             hs;
      logic [31:0]    p0;
      logic [IDW-1:0] id0;
      do_reset();
      cur_a = {16'd4, 16'd3, 16'd2, 16'h00AB};
      cur_b = {16'd8, 16'd7, 16'd6, 16'h0CD0};
      run_cycle(4'b1111, 1'b0, hs);
      run_cycle(4'b1111, 1'b0, hs);
      p0  = bus.rsp_prod;
      id0 = bus.rsp_id;
      checks++;
      if (p0 !== 32'h00AB * 32'h0CD0 || id0 !== '0) begin
         failures++;
         $display("FAIL stall_first: got id=%0d prod=%h expected id=0 prod=%h", id0, p0, 32'h00AB * 32'h0CD0);
      end
      for (int c = 0; c < 5; c++) begin
         run_cycle(4'b1111, 1'b0, hs);
         checks++;
         if (bus.rsp_prod !== p0 || bus.rsp_id !== id0 || bus.req_ready !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: got prod=%h id=%0d req_ready=%b busy=%b expected prod=%h id=%0d req_ready=0 busy=1",
                     bus.rsp_prod, bus.rsp_id, bus.req_ready, busy, p0, id0);
         end
      end
      run_cycle(4'b1111, 1'b1, hs);
      checks++;
      if (done_cnt !== 16'd1 || hs != 0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL stall_release: got done_cnt=%0d id=%0d busy=%b expected 1, 0, 1", done_cnt, hs, busy);
      end
   endtask

   task automatic test_async_reset();
      int hs;
      do_reset();
      cur_a = '0; cur_b = '0;
      cur_a[15:0] = 16'd7;  cur_b[15:0] = 16'd9;
      cur_a[47:32] = 16'd5; cur_b[47:32] = 16'd11;
      run_cycle(4'b0101, 1'b1, hs);
      run_cycle(4'b0101, 1'b1, hs);
      run_cycle(4'b0101, 1'b1, hs);
      // Now in CALC for requester 2, one op completed.
      #2;
      bus.req_valid = '0;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_prod !== '0 || bus.rsp_id !== '0 || busy !== 1'b0 || done_cnt !== '0) begin
         failures++;
         $display("FAIL async_reset: got rsp_valid=%b prod=%h id=%0d busy=%b done=%0d expected all zero",
                  bus.rsp_valid, bus.rsp_prod, bus.rsp_id, busy, done_cnt);
      end
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      run_cycle(4'b0101, 1'b1, hs);
      run_cycle(4'b0101, 1'b1, hs);
      run_cycle(4'b0101, 1'b1, hs);
      checks++;
      if (hs != 0 || done_cnt !== 16'd1) begin
         failures++;
         $display("FAIL post_reset_grant: got id=%0d done=%0d expected id=0 done=1", hs, done_cnt);
      end
   endtask

   task automatic test_two_req();
      int hs;
      int n = 0;
      int exp_ids[4];
`ifdef DADDA_ARB_PRIO_EN
      exp_ids = '{0, 0, 0, 0};
`else
      exp_ids = '{0, 2, 0, 2};
`endif
      do_reset();
      for (int c = 0; c < 20 && n < 4; c++) begin
         run_cycle(4'b0101, 1'b1, hs);
         if (hs >= 0) begin
            checks++;
            if (hs !== exp_ids[n]) begin
               failures++;
               $display("FAIL two_req_order: handshake %0d got id=%0d expected id=%0d", n, hs, exp_ids[n]);
            end
            n++;
         end
      end
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL two_req_count: got %0d handshakes expected 4", n);
      end
   endtask

   task automatic test_random();
      int          hs;
      int          ops = 0;
      int          cyc = 0;
      int          r;
      logic [15:0] val;
      do_reset();
      while (ops < 1000 && cyc < 20000) begin
         for (int i = 0; i < 2 * NREQ; i++) begin
            r   = $urandom_range(0, 7);
            val = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
            if (i < NREQ) cur_a[i*WIDTH +: WIDTH] = val;
            else          cur_b[(i-NREQ)*WIDTH +: WIDTH] = val;
         end
         run_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), hs);
         if (hs >= 0) ops++;
         cyc++;
      end
      for (int c = 0; c < 10 && sb.size() > 0; c++) run_cycle(4'b0000, 1'b1, hs);
      checks++;
      if (ops < 1000 || sb.size() != 0) begin
         failures++;
         $display("FAIL random_drain: got ops=%0d pending=%0d expected ops>=1000 pending=0", ops, sb.size());
      end
      for (int i = 0; i < NREQ; i++) begin
         checks++;
         if (issued[i] != completed[i]) begin
            failures++;
            $display("FAIL random_per_req: requester %0d got completed=%0d expected %0d", i, completed[i], issued[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_async_reset();
      test_two_req();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
`default_nettype wire
